// File: rtl/binenc_scan.sv
// binenc_scan: captures a bit vector and emits the index of each set bit, one beat per handshake.
// Define BINENC_SCAN_COUNT_EN to add the registered popcount output 'count'.
module binenc_scan #(
  parameter int A_width    = 32,
  parameter int ADDR_width = 6,
  parameter bit LSB_FIRST  = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [A_width-1:0]    A,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_width-1:0] ADDR,
  output logic                  out_last,
  output logic                  out_none
`ifdef BINENC_SCAN_COUNT_EN
  ,
  output logic [ADDR_width:0]   count
`endif
);
  if (A_width < 2 || A_width > 1024 || (2 ** ADDR_width) - 1 < A_width) begin : g_bad_cfg
    $error("binenc_scan: illegal A_width/ADDR_width combination");
  end
  typedef enum logic {IDLE, SCAN} state_t;
  state_t r_state, w_next;
  logic [A_width-1:0]    r_work;
  logic [ADDR_width-1:0] w_idx;
  logic w_empty, w_single, w_capture, w_fire;
  assign w_empty   = r_work == '0;
  assign w_single  = !w_empty && ((r_work & (r_work - A_width'(1))) == '0);
  assign in_ready  = r_state == IDLE;
  assign out_valid = r_state == SCAN;
  assign out_last  = out_valid && (w_empty || w_single);
  assign out_none  = out_valid && w_empty;
  assign ADDR      = out_valid ? w_idx : '1;
  assign w_capture = in_ready && in_valid;
  assign w_fire    = out_valid && out_ready;
  // Later matches override earlier ones, so the scan order decides which end wins.
  always_comb begin
    w_idx = '1;
    for (int i = 0; i < A_width; i++)
      if (r_work[LSB_FIRST ? A_width - 1 - i : i]) w_idx = ADDR_width'(LSB_FIRST ? A_width - 1 - i : i);
  end
  always_comb begin
    w_next = (r_state == IDLE) ? (in_valid ? SCAN : IDLE) : ((out_ready && out_last) ? IDLE : SCAN);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_work <= '0;
    else if (w_capture) r_work <= A;
    else if (w_fire)    r_work <= r_work & ~(A_width'(1) << w_idx);
  end
`ifdef BINENC_SCAN_COUNT_EN
  logic [ADDR_width:0] r_count, w_pop;
  always_comb begin
    w_pop = '0;
    for (int i = 0; i < A_width; i++) w_pop = w_pop + (ADDR_width + 1)'(A[i]);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_count <= '0;
    else if (w_capture)           r_count <= w_pop;
    else if (w_fire && out_last)  r_count <= '0;
  end
  assign count = r_count;
`endif
endmodule

// File: tb/tb_binenc_scan.sv
// tb_binenc_scan: randomized self-checking bench for binenc_scan in both scan orders.
module tb_binenc_scan;
  localparam int AW = 32;
  localparam int DW = 6;
  logic clk = 1'b0;
  logic rst;
  logic iv [2];
  logic ordy [2];
  logic ir [2];
  logic ov [2];
  logic last [2];
  logic none [2];
  logic [AW-1:0] av [2];
  logic [DW-1:0] addr [2];
`ifdef BINENC_SCAN_COUNT_EN
  logic [DW:0] cnt [2];
`endif
  int checks = 0;
  int fails = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : g_dut
    binenc_scan #(.A_width(AW), .ADDR_width(DW), .LSB_FIRST(g == 1)) dut (
      .clk(clk), .rst(rst), .in_valid(iv[g]), .in_ready(ir[g]), .A(av[g]),
      .out_valid(ov[g]), .out_ready(ordy[g]), .ADDR(addr[g]), .out_last(last[g]), .out_none(none[g])
`ifdef BINENC_SCAN_COUNT_EN
      , .count(cnt[g])
`endif
    );
  end

  // mode: 0 always ready, 1 ready toggling 1,0,1,0..., 2 random stalls; noise drives in_valid/A during the scan
  task automatic run_vec(input int l, input logic [AW-1:0] a, input int mode, input bit noise);
    int q[$];
    int pc, n, k, cyc;
    for (int i = 0; i < AW; i++) if (a[i]) q.push_back(i);
    if (l == 0) q.reverse();
    pc = q.size();
    if (pc == 0) q.push_back(2 ** DW - 1);
    n = q.size();
    k = 0;
    cyc = 0;
    @(negedge clk);
    checks++;
    if (ir[l] !== 1'b1) begin fails++; $display("FAIL accept l=%0d in_ready=%b want 1", l, ir[l]); end
    iv[l] = 1'b1;
    av[l] = a;
    @(negedge clk);
    iv[l] = 1'b0;
    while (k < n && cyc < 400) begin
      checks++;
      if (ov[l] !== 1'b1 || addr[l] !== DW'(q[k]) || last[l] !== (k == n - 1) || none[l] !== (pc == 0)) begin
        fails++;
        $display("FAIL beat l=%0d a=%h k=%0d got v=%b addr=%0d last=%b none=%b want v=1 addr=%0d last=%b none=%b",
                 l, a, k, ov[l], addr[l], last[l], none[l], q[k], k == n - 1, pc == 0);
      end
`ifdef BINENC_SCAN_COUNT_EN
      checks++;
      if (cnt[l] !== (DW + 1)'(pc)) begin fails++; $display("FAIL count l=%0d a=%h got %0d want %0d", l, a, cnt[l], pc); end
`endif
      ordy[l] = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      if (noise) begin iv[l] = 1'($urandom_range(0, 1)); av[l] = $urandom; end
      @(posedge clk);
      if (ordy[l]) k++;
      @(negedge clk);
      cyc++;
    end
    iv[l] = 1'b0;
    ordy[l] = 1'b0;
    checks++;
    if (cyc >= 400) begin fails++; $display("FAIL timeout l=%0d a=%h beats=%0d want %0d", l, a, k, n); end
    checks++;
    if (ir[l] !== 1'b1 || ov[l] !== 1'b0 || addr[l] !== '1 || last[l] !== 1'b0 || none[l] !== 1'b0) begin
      fails++;
      $display("FAIL idle_after l=%0d got rdy=%b v=%b addr=%h last=%b none=%b want 1 0 3f 0 0", l, ir[l], ov[l], addr[l], last[l], none[l]);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int l = 0; l < 2; l++) begin iv[l] = 1'b0; ordy[l] = 1'b0; av[l] = '0; end
    repeat (3) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      checks++;
      if (ir[l] !== 1'b1 || ov[l] !== 1'b0 || addr[l] !== '1 || last[l] !== 1'b0 || none[l] !== 1'b0) begin
        fails++;
        $display("FAIL reset l=%0d got rdy=%b v=%b addr=%h last=%b none=%b want 1 0 3f 0 0", l, ir[l], ov[l], addr[l], last[l], none[l]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    run_vec(0, 32'h8000_0001, 0, 1'b0);
    run_vec(0, 32'h0, 0, 1'b0);
    run_vec(1, 32'h0, 1, 1'b0);
    run_vec(1, 32'h0000_00F0, 1, 1'b0);
    run_vec(0, 32'h0000_0001, 2, 1'b0);
    run_vec(1, 32'h8000_0000, 2, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_vec(0, 32'hFFFF_FFFF, 0, 1'b1);
    run_vec(1, 32'hFFFF_FFFF, 2, 1'b1);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    iv[0] = 1'b1;
    av[0] = 32'h0000_00FF;
    @(negedge clk);
    iv[0] = 1'b0;
    ordy[0] = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (ov[0] !== 1'b1 || addr[0] !== 6'd5) begin fails++; $display("FAIL pre_rst got v=%b addr=%0d want 1 5", ov[0], addr[0]); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (ov[0] !== 1'b0 || addr[0] !== '1 || last[0] !== 1'b0 || none[0] !== 1'b0 || ir[0] !== 1'b1) begin
      fails++;
      $display("FAIL mid_rst got v=%b addr=%h last=%b none=%b rdy=%b want 0 3f 0 0 1", ov[0], addr[0], last[0], none[0], ir[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    ordy[0] = 1'b0;
    run_vec(0, 32'h0000_0004, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    for (int i = 0; i < 1500; i++)
      for (int l = 0; l < 2; l++) begin
        a = (i % 50 == 0) ? '0 : (i % 3 == 0) ? $urandom : ($urandom & $urandom & $urandom);
        run_vec(l, a, 2, i[0]);
      end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
